// File: rtl/cnt_bcd_seg_scan.sv
// cnt_bcd_seg_scan: samples an 8-bit upstream count, converts it to three BCD
// digits with a sequential double-dabble engine, and drives a 3-digit
// multiplexed 7-segment display with leading-zero blanking.
module cnt_bcd_seg_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cnt,
  output logic [11:0] bcd,
  output logic        busy,
  output logic [2:0]  sel,
  output logic [7:0]  seg
);

  localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  state_t              state_q, state_d;
  logic [19:0]         sr_q, sr_d;
  logic [7:0]          cap_q, cap_d;
  logic [2:0]          iter_q, iter_d;
  logic                busy_q, busy_d;
  logic [11:0]         bcd_q, bcd_d;
  logic [7:0]          cnt_last_q, cnt_last_d;
  logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic [2:0]          sel_q, sel_d;
  logic [7:0]          seg_q, seg_d;

  // One double-dabble iteration: correct each BCD nibble >= 5, then shift left.
  function automatic logic [19:0] dabble_step(input logic [19:0] sr);
    logic [19:0] adj;
    adj = sr;
    for (int i = 0; i < 3; i++) begin
      if (adj[8+4*i +: 4] >= 4'd5)
        adj[8+4*i +: 4] = adj[8+4*i +: 4] + 4'd3;
    end
    return {adj[18:0], 1'b0};
  endfunction

  // Active-low glyph for a decimal digit; blank turns every segment off.
  function automatic logic [7:0] glyph(input logic [3:0] d, input logic blank);
    logic [7:0] code;
    case (d)
      4'd0:    code = 8'hC0;
      4'd1:    code = 8'hF9;
      4'd2:    code = 8'hA4;
      4'd3:    code = 8'hB0;
      4'd4:    code = 8'h99;
      4'd5:    code = 8'h92;
      4'd6:    code = 8'h82;
      4'd7:    code = 8'hF8;
      4'd8:    code = 8'h80;
      4'd9:    code = 8'h90;
      default: code = 8'hFF;
    endcase
    if (blank) code = 8'hFF;
    return code;
  endfunction

  // FSM state register; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: wait for a new count, run 8 shifts, then publish.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cnt != cnt_last_q) state_d = SHIFT;
      SHIFT:   if (iter_q == 3'd7)    state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: capture, shift-add-3 iterations, and result publication.
  always_comb begin
    sr_d       = sr_q;
    cap_d      = cap_q;
    iter_d     = iter_q;
    busy_d     = busy_q;
    bcd_d      = bcd_q;
    cnt_last_d = cnt_last_q;
    case (state_q)
      IDLE: begin
        if (cnt != cnt_last_q) begin
          sr_d   = {12'b0, cnt};
          cap_d  = cnt;
          iter_d = 3'd0;
          busy_d = 1'b1;
        end
      end
      SHIFT: begin
        sr_d   = dabble_step(sr_q);
        iter_d = iter_q + 3'd1;
      end
      UPDATE: begin
        bcd_d      = sr_q[19:8];
        cnt_last_d = cap_q;
        busy_d     = 1'b0;
      end
      default: ;
    endcase
  end

  // Digit scan: slot timer and digit index, advancing on the slot wrap.
  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
  end

  // Display drive: enable digit idx and show its glyph, blanking leading zeros.
  always_comb begin
    logic [3:0] digit;
    logic       blank;
    logic [2:0] onehot;
    logic [7:0] code;
    digit  = bcd_q[3:0];
    blank  = 1'b0;
    onehot = 3'b001;
    case (idx_q)
      2'd1: begin
        digit  = bcd_q[7:4];
        blank  = (bcd_q[11:4] == 8'h00);
        onehot = 3'b010;
      end
      2'd2: begin
        digit  = bcd_q[11:8];
        blank  = (bcd_q[11:8] == 4'h0);
        onehot = 3'b100;
      end
      default: ;
    endcase
    code  = glyph(digit, blank);
    sel_d = DIG_ACTIVE_LOW ? ~onehot : onehot;
    seg_d = SEG_ACTIVE_LOW ? code : ~code;
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_q     <= 3'd0;
      busy_q     <= 1'b0;
      bcd_q      <= 12'h000;
      cnt_last_q <= 8'h00;
      scan_cnt_q <= '0;
      idx_q      <= 2'd0;
      sel_q      <= DIG_ACTIVE_LOW ? 3'b110 : 3'b001;
      seg_q      <= SEG_ACTIVE_LOW ? 8'hC0 : 8'h3F;
    end else begin
      iter_q     <= iter_d;
      busy_q     <= busy_d;
      bcd_q      <= bcd_d;
      cnt_last_q <= cnt_last_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
    end
  end

  // Conversion datapath; only read after a capture, so it needs no reset.
  always_ff @(posedge clk) begin
    sr_q  <= sr_d;
    cap_q <= cap_d;
  end

  assign bcd  = bcd_q;
  assign busy = busy_q;
  assign sel  = sel_q;
  assign seg  = seg_q;

endmodule

// File: tb/tb_cnt_bcd_seg_scan.sv
// Bench for cnt_bcd_seg_scan with a transaction-level reference model.
module tb_cnt_bcd_seg_scan;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cnt = 8'd0;
  logic [11:0] bcd;
  logic        busy;
  logic [2:0]  sel;
  logic [7:0]  seg;

  int vectors = 0;
  int miscompares = 0;

  always #10 clk = ~clk;

  cnt_bcd_seg_scan #(.SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .cnt(cnt), .bcd(bcd), .busy(busy), .sel(sel), .seg(seg)
  );

  // Reference model: conversion takes 9 clocks after capture, digits by arithmetic.
  int         m_phase, m_cap, m_last, m_val, m_n;
  logic [2:0] m_sel;
  logic [7:0] m_seg;
  logic [23:0] dut_vec, mdl_vec;

  function automatic logic [11:0] bcd_of(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [2:0] sel_f(input int n);
    int k;
    k = (n / SCAN_DIV) % 3;
    return ~(3'b001 << k);
  endfunction

  function automatic logic [7:0] seg_f(input int v, input int n);
    int k, d;
    k = (n / SCAN_DIV) % 3;
    d = (k == 0) ? v % 10 : (k == 1) ? (v / 10) % 10 : v / 100;
    if ((k == 2 && v < 100) || (k == 1 && v < 10)) return 8'hFF;
    case (d)
      0: return 8'hC0; 1: return 8'hF9; 2: return 8'hA4; 3: return 8'hB0;
      4: return 8'h99; 5: return 8'h92; 6: return 8'h82; 7: return 8'hF8;
      8: return 8'h80; default: return 8'h90;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_cap <= 0; m_last <= 0; m_val <= 0; m_n <= 0;
      m_sel <= sel_f(0); m_seg <= seg_f(0, 0);
    end else begin
      if (m_phase == 0) begin
        if (int'(cnt) != m_last) begin
          m_cap   <= int'(cnt);
          m_phase <= 1;
        end
      end else if (m_phase == 9) begin
        m_val   <= m_cap;
        m_last  <= m_cap;
        m_phase <= 0;
      end else begin
        m_phase <= m_phase + 1;
      end
      m_sel <= sel_f(m_n);
      m_seg <= seg_f(m_val, m_n);
      m_n   <= m_n + 1;
    end
  end

  assign dut_vec = {bcd, busy, sel, seg};
  assign mdl_vec = {bcd_of(m_val), (m_phase != 0), m_sel, m_seg};

  // Stimulus helper: reset with a given count held on cnt, released on a falling edge.
  task automatic apply_reset(input logic [7:0] v);
    @(negedge clk);
    rst = 1'b1;
    cnt = v;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] sel_seq [0:2];
    logic [2:0] want_sel;
    sel_seq[0] = 3'b110; sel_seq[1] = 3'b101; sel_seq[2] = 3'b011;
    @(negedge clk);
    rst = 1'b1; cnt = 8'd0;
    @(negedge clk);
    vectors++;
    if (dut_vec !== 24'h000_6C0) begin
      miscompares++;
      $display("FAIL reset_values got %h want %h", dut_vec, 24'h000_6C0);
    end
    rst = 1'b0;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      want_sel = sel_seq[((j - 1) / SCAN_DIV) % 3];
      vectors++;
      if (dut_vec !== mdl_vec || busy !== 1'b0 || bcd !== 12'h000 || sel !== want_sel ||
          seg !== ((want_sel == 3'b110) ? 8'hC0 : 8'hFF)) begin
        miscompares++;
        $display("FAIL reset_hold cyc %0d got %h want %h sel_want %b", j, dut_vec, mdl_vec, want_sel);
      end
    end
  endtask

  task automatic test_max_255();
    int busy_cycles = 0;
    apply_reset(8'd255);
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cycles++;
      vectors++;
      if (dut_vec !== mdl_vec) begin
        miscompares++;
        $display("FAIL max255_model cyc %0d got %h want %h", j, dut_vec, mdl_vec);
      end
      if (j == 10) begin
        vectors++;
        if (bcd !== 12'h255 || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL max255_result got bcd=%h busy=%b want bcd=255 busy=0", bcd, busy);
        end
      end
      if (j >= 12) begin
        vectors++;
        if (seg !== ((sel == 3'b011) ? 8'hA4 : 8'h92)) begin
          miscompares++;
          $display("FAIL max255_seg sel=%b got %h", sel, seg);
        end
      end
    end
    vectors++;
    if (busy_cycles != 9) begin
      miscompares++;
      $display("FAIL max255_busy_len got %0d want 9", busy_cycles);
    end
  endtask

  task automatic test_seven();
    apply_reset(8'd7);
    for (int j = 1; j <= 26; j++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec !== mdl_vec) begin
        miscompares++;
        $display("FAIL seven_model cyc %0d got %h want %h", j, dut_vec, mdl_vec);
      end
      if (j == 10) begin
        vectors++;
        if (bcd !== 12'h007) begin
          miscompares++;
          $display("FAIL seven_result got %h want 007", bcd);
        end
      end
      if (j >= 12) begin
        vectors++;
        if (seg !== ((sel == 3'b110) ? 8'hF8 : 8'hFF)) begin
          miscompares++;
          $display("FAIL seven_seg sel=%b got %h", sel, seg);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    apply_reset(8'd100);
    for (int j = 1; j <= 24; j++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec !== mdl_vec) begin
        miscompares++;
        $display("FAIL b2b_model cyc %0d got %h want %h", j, dut_vec, mdl_vec);
      end
      if (j == 10) begin
        vectors++;
        if (bcd !== 12'h100 || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_first got bcd=%h busy=%b want bcd=100 busy=0", bcd, busy);
        end
      end
      if (j == 11) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_restart got busy=%b want 1", busy);
        end
      end
      if (j == 20) begin
        vectors++;
        if (bcd !== 12'h200) begin
          miscompares++;
          $display("FAIL b2b_second got %h want 200", bcd);
        end
      end
      if (j == 3) cnt = 8'd200;
    end
  endtask

  task automatic test_reset_mid();
    apply_reset(8'd150);
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec !== mdl_vec) begin
        miscompares++;
        $display("FAIL rstmid_pre cyc %0d got %h want %h", j, dut_vec, mdl_vec);
      end
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || bcd !== 12'h000 || sel !== 3'b110 || seg !== 8'hC0) begin
      miscompares++;
      $display("FAIL rstmid_abort got %h want 0006c0", dut_vec);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec !== mdl_vec) begin
        miscompares++;
        $display("FAIL rstmid_post cyc %0d got %h want %h", j, dut_vec, mdl_vec);
      end
      if (j == 10) begin
        vectors++;
        if (bcd !== 12'h150) begin
          miscompares++;
          $display("FAIL rstmid_result got %h want 150", bcd);
        end
      end
    end
  endtask

  task automatic test_free_running();
    int last_upd = -1;
    logic [11:0] prev_bcd;
    apply_reset(8'd0);
    prev_bcd = 12'h000;
    for (int j = 1; j <= 300; j++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec !== mdl_vec) begin
        miscompares++;
        $display("FAIL freerun_model cyc %0d got %h want %h", j, dut_vec, mdl_vec);
      end
      if (bcd[3:0] > 4'd9 || bcd[7:4] > 4'd9 || bcd[11:8] > 4'd9) begin
        miscompares++;
        $display("FAIL freerun_nibble got %h want nibbles <= 9", bcd);
      end
      if (bcd !== prev_bcd) begin
        vectors++;
        if (last_upd >= 0 && (j - last_upd) != 10) begin
          miscompares++;
          $display("FAIL freerun_spacing got %0d want 10", j - last_upd);
        end
        last_upd = j;
        prev_bcd = bcd;
      end
      cnt = cnt + 8'd1;
    end
    vectors++;
    if (last_upd < 0) begin
      miscompares++;
      $display("FAIL freerun_no_update got none want updates");
    end
  endtask

  task automatic test_random();
    int hold = 0;
    apply_reset(8'($urandom_range(0, 255)));
    repeat (600) begin
      @(negedge clk);
      vectors++;
      if (dut_vec !== mdl_vec) begin
        miscompares++;
        $display("FAIL random_model got %h want %h (rst=%b cnt=%0d)", dut_vec, mdl_vec, rst, cnt);
      end
      rst = 1'b0;
      if (hold == 0) begin
        cnt  = 8'($urandom_range(0, 255));
        hold = $urandom_range(1, 25);
      end
      hold--;
      if ($urandom_range(0, 59) == 0) rst = 1'b1;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_max_255();
    test_seven();
    test_back_to_back();
    test_reset_mid();
    test_free_running();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
